// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode from a small prefetch FIFO.
// Optional feature macro: FETCH_PERF_CNT_EN adds stall_cnt/flush_cnt outputs.
// Contains a generic flushable FIFO (fifo) and the fetch_unit top.

// Generic synchronous FIFO with count output and single-cycle flush.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: caller must not push when full; pop of an empty FIFO is ignored.
module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign pop_ok   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage write; entries need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Fetch PC owner: issues imem reads, buffers {inst, pc}, hands them to decode.
// Latency: issue at t, entry pushed at end of t+1, id_valid in t+2; jump -> id_valid t+3.
// Backpressure: id_ready=0 holds the head; issue stops once buffered+in-flight reaches DEPTH.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int          CW  = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic        issue;
  logic        pop;
  fetch_ent_t  push_dat;
  fetch_ent_t  head_dat;

  // Slots already promised: buffered entries plus the read still in flight
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = !reset && !jump_flag && (occupancy < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  assign push_dat.inst = imem_data;
  assign push_dat.pc   = inflight_pc;

  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready;
  assign id_inst  = id_valid ? head_dat.inst : NOP;
  assign id_pc    = id_valid ? head_dat.pc   : 32'h0;

  // Prefetch buffer; a jump flushes it and drops the response arriving now
  fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (jump_flag),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  // Fetch PC advance, redirect on jump, and in-flight read tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (jump_flag) begin
      fetch_pc <= {jump_target[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters for decode stall cycles and flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (id_valid && !id_ready && (stall_cnt != 32'hFFFFFFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (jump_flag && (flush_cnt != 32'hFFFFFFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, wrap-around instance, random run.
// The imem model returns a fixed scramble of the read address one cycle later.
// A timestamped queue model checks every cycle from reset onwards.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] w_stall_cnt;
  logic [31:0] w_flush_cnt;
`endif

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data = 32'h0;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  always @(posedge clk) imem_data <= inst_of(imem_addr);
  always @(posedge clk) w_data    <= inst_of(w_addr);

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .jump_flag(jump_flag), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .reset(reset), .jump_flag(1'b0), .jump_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_data(w_data),
    .id_valid(w_valid), .id_ready(1'b1), .id_inst(w_inst), .id_pc(w_pc)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model: queue of issued PCs with visibility time
  typedef struct {
    logic [31:0] pc;
    int          rdy;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_next_pc = 32'h0;
  int          m_cyc = 0;
  bit          m_on = 1'b0;
  bit          m_ev;
  bit          m_ereq;
  logic [31:0] m_epc;
  logic [31:0] m_einst;

  always @(negedge clk) begin
    if (m_on) begin
      m_ev    = (mq.size() > 0) && (mq[0].rdy <= m_cyc);
      m_epc   = m_ev ? mq[0].pc : 32'h0;
      m_einst = m_ev ? inst_of(mq[0].pc) : NOP;
      m_ereq  = !reset && !jump_flag && (mq.size() < DEPTH);
      chk("model_id_valid", {31'b0, id_valid}, {31'b0, m_ev});
      chk("model_id_pc", id_pc, m_epc);
      chk("model_id_inst", id_inst, m_einst);
      chk("model_imem_req", {31'b0, imem_req}, {31'b0, m_ereq});
      if (m_ereq) chk("model_imem_addr", imem_addr, m_next_pc);
      if (reset) begin
        mq.delete();
        m_next_pc = 32'h0;
      end else if (jump_flag) begin
        mq.delete();
        m_next_pc = {jump_target[31:2], 2'b00};
      end else begin
        if (m_ev && id_ready) void'(mq.pop_front());
        if (m_ereq) begin
          mq.push_back('{pc: m_next_pc, rdy: m_cyc + 2});
          m_next_pc = m_next_pc + 32'd4;
        end
      end
      m_cyc++;
    end
  end

  // ---------------- directed cycle table
  typedef struct {
    bit          rst;
    bit          jmp;
    logic [31:0] tgt;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_req;
    logic [31:0] e_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic row(input bit r, input bit j, input logic [31:0] t, input bit rd,
                     input bit ev, input logic [31:0] epc, input bit erq, input logic [31:0] ea);
    vecs.push_back('{rst: r, jmp: j, tgt: t, rdy: rd, e_valid: ev, e_pc: epc, e_req: erq, e_addr: ea});
  endtask

  initial begin
    // reset state
    row(1, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    // streaming from RESET_PC
    row(0, 0, 0, 1, 0, 32'h0, 1, 32'h0);
    row(0, 0, 0, 1, 0, 32'h0, 1, 32'h4);
    row(0, 0, 0, 1, 1, 32'h0, 1, 32'h8);
    row(0, 0, 0, 1, 1, 32'h4, 1, 32'hC);
    row(0, 0, 0, 1, 1, 32'h8, 1, 32'h10);
    // decode stalled for 10 cycles
    row(0, 0, 0, 0, 1, 32'hC, 1, 32'h14);
    row(0, 0, 0, 0, 1, 32'hC, 1, 32'h18);
    for (int i = 0; i < 8; i++) row(0, 0, 0, 0, 1, 32'hC, 0, 32'h0);
    // release: drain in order, issue resumes
    row(0, 0, 0, 1, 1, 32'hC,  0, 32'h0);
    row(0, 0, 0, 1, 1, 32'h10, 1, 32'h1C);
    row(0, 0, 0, 1, 1, 32'h14, 1, 32'h20);
    row(0, 0, 0, 1, 1, 32'h18, 1, 32'h24);
    row(0, 0, 0, 1, 1, 32'h1C, 1, 32'h28);
    row(0, 0, 0, 1, 1, 32'h20, 1, 32'h2C);
    // fill up, then jump with unaligned target while 3 buffered + 1 in flight
    row(0, 0, 0,        0, 1, 32'h24, 1, 32'h30);
    row(0, 1, 32'h103,  0, 1, 32'h24, 0, 32'h0);
    row(0, 0, 0, 1, 0, 32'h0,   1, 32'h100);
    row(0, 0, 0, 1, 0, 32'h0,   1, 32'h104);
    row(0, 0, 0, 1, 1, 32'h100, 1, 32'h108);
    row(0, 0, 0, 1, 1, 32'h104, 1, 32'h10C);
    // jump coinciding with a pop: flush wins, no stale PC follows
    row(0, 1, 32'h200, 1, 1, 32'h108, 0, 32'h0);
    row(0, 0, 0, 1, 0, 32'h0,   1, 32'h200);
    row(0, 0, 0, 1, 0, 32'h0,   1, 32'h204);
    row(0, 0, 0, 1, 1, 32'h200, 1, 32'h208);
    // one-cycle reset mid-stream
    row(1, 0, 0, 1, 1, 32'h204, 0, 32'h0);
    row(0, 0, 0, 1, 0, 32'h0,   1, 32'h0);
    row(0, 0, 0, 1, 0, 32'h0,   1, 32'h4);
    row(0, 0, 0, 1, 1, 32'h0,   1, 32'h8);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      m_on        = 1'b1;
      reset       = vecs[k].rst;
      jump_flag   = vecs[k].jmp;
      jump_target = vecs[k].tgt;
      id_ready    = vecs[k].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_id_valid", k), {31'b0, id_valid}, {31'b0, vecs[k].e_valid});
      chk($sformatf("vec%0d_id_pc", k), id_pc, vecs[k].e_pc);
      chk($sformatf("vec%0d_id_inst", k), id_inst,
          vecs[k].e_valid ? inst_of(vecs[k].e_pc) : NOP);
      chk($sformatf("vec%0d_imem_req", k), {31'b0, imem_req}, {31'b0, vecs[k].e_req});
      if (vecs[k].e_req) chk($sformatf("vec%0d_imem_addr", k), imem_addr, vecs[k].e_addr);
      // RESET_PC near the top of the address space wraps to zero
      if (k >= 1 && k <= 3) begin
        chk($sformatf("wrap%0d_req", k), {31'b0, w_req}, 32'd1);
        chk($sformatf("wrap%0d_addr", k), w_addr, 32'hFFFFFFF8 + 32'(4 * (k - 1)));
      end
`ifdef FETCH_PERF_CNT_EN
      if (k == 21) begin
        chk("stall_cnt_after_stall", stall_cnt, 32'd10);
        chk("flush_cnt_after_stall", flush_cnt, 32'd0);
      end
`endif
    end

    // randomized traffic, checked by the model process
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset       = ($urandom_range(0, 99) == 0);
      jump_flag   = ($urandom_range(0, 11) == 0);
      jump_target = $urandom;
      id_ready    = (n % 200 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
